// File: rtl/sregs_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : sregs_ctl
//  Brief    : Special-register bank for the pcpu core. Holds the runtime mode
//             (SUP / INA / IE), the boot/JTR mode with deferred commit on
//             jump-class instructions, an interrupt save slot and NSCRATCH
//             supervisor scratch registers. Readback is combinational.
//  Options  : SREGS_IRQ_EN - compiles in interrupt accept, SR3 save slot,
//             IRT restore and irq_ack. Undefined: irq_req ignored,
//             irq_ack tied low, SR3 reads 0.
//  Revision : 1.0 - initial release
// ============================================================================
module sregs_ctl #(
   parameter int DATA_W   = 16,
   parameter int NSCRATCH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sr_ie,
   input  logic [15:0]       sr_sel,
   input  logic [DATA_W-1:0] sr_in,
   input  logic [6:0]        instr_op,
   input  logic              irq_req,
   output logic [DATA_W-1:0] sr_out,
   output logic              boot_mode,
   output logic              instr_mem_over,
   output logic              sup_mode,
   output logic              irq_en,
   output logic              irq_ack
);

   localparam logic [6:0]  OP_JMP_A  = 7'b0001110;
   localparam logic [6:0]  OP_JMP_B  = 7'b0001111;
   localparam logic [6:0]  OP_IRT    = 7'b0010001;
   localparam logic [2:0]  MODE_RST  = 3'b001;
   localparam int          SCR_BASE  = 4;
   // Keep the scratch array legal when no scratch registers are configured
   localparam int          NS_ARR    = (NSCRATCH > 0) ? NSCRATCH : 1;

   // Architectural state
   logic [2:0]        mode_q, mode_d;          // {IE, INA, SUP}
   logic              jtr_buf_q, jtr_buf_d;
   logic              boot_mode_q, boot_mode_d;
   logic [DATA_W-1:0] scratch_q [NS_ARR];
   logic [DATA_W-1:0] scratch_d [NS_ARR];
`ifdef SREGS_IRQ_EN
   logic [2:0]        save_q, save_d;
   logic              irq_ack_q, irq_ack_d;
   logic              accept;
`endif

   // Instruction decode shared by commit and restore
   logic is_irt;
   logic jtr_commit;
   logic priv_wr;

   // Decode IRT / JTR commit and the privileged-write qualifier
   always_comb begin
      is_irt     = (instr_op == OP_IRT) && (sr_sel == 16'd0);
      jtr_commit = (instr_op == OP_JMP_A) || (instr_op == OP_JMP_B) || is_irt;
      priv_wr    = sr_ie && mode_q[0];
   end

   // Next-state: software writes, then interrupt accept, then IRT restore
   // (later assignments win, giving IRT > accept > SR1 write)
   always_comb begin
      mode_d      = mode_q;
      jtr_buf_d   = jtr_buf_q;
      boot_mode_d = boot_mode_q;
      scratch_d   = scratch_q;

      if (priv_wr && (sr_sel == 16'd1)) begin
         mode_d = sr_in[2:0];
      end

      // SR2 write is unprivileged; commit deliberately samples the old buffer
      if (sr_ie && (sr_sel == 16'd2)) begin
         jtr_buf_d = sr_in[0];
      end
      if (jtr_commit) begin
         boot_mode_d = jtr_buf_q;
      end

      for (int i = 0; i < NSCRATCH; i++) begin
         if (priv_wr && (sr_sel == 16'(i + SCR_BASE))) begin
            scratch_d[i] = sr_in;
         end
      end

`ifdef SREGS_IRQ_EN
      save_d    = save_q;
      accept    = irq_req && mode_q[2] && !is_irt;
      irq_ack_d = accept;

      if (priv_wr && (sr_sel == 16'd3)) begin
         save_d = sr_in[2:0];
      end
      if (accept) begin
         save_d = mode_q;
         mode_d = MODE_RST;
      end
      if (is_irt) begin
         mode_d = save_q;
      end
`endif
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q      <= MODE_RST;
         jtr_buf_q   <= 1'b1;
         boot_mode_q <= 1'b1;
         for (int i = 0; i < NS_ARR; i++) begin
            scratch_q[i] <= '0;
         end
`ifdef SREGS_IRQ_EN
         save_q      <= 3'b000;
         irq_ack_q   <= 1'b0;
`endif
      end else begin
         mode_q      <= mode_d;
         jtr_buf_q   <= jtr_buf_d;
         boot_mode_q <= boot_mode_d;
         for (int i = 0; i < NS_ARR; i++) begin
            scratch_q[i] <= scratch_d[i];
         end
`ifdef SREGS_IRQ_EN
         save_q      <= save_d;
         irq_ack_q   <= irq_ack_d;
`endif
      end
   end

   // Combinational readback; unused bits and unmapped indices read 0
   always_comb begin
      sr_out = '0;
      if (sr_sel == 16'd1) begin
         sr_out = DATA_W'(mode_q);
      end else if (sr_sel == 16'd2) begin
         sr_out = DATA_W'({jtr_buf_q, boot_mode_q});
`ifdef SREGS_IRQ_EN
      end else if (sr_sel == 16'd3) begin
         sr_out = DATA_W'(save_q);
`endif
      end else begin
         // Scratch contents are hidden from user mode
         for (int i = 0; i < NSCRATCH; i++) begin
            if (mode_q[0] && (sr_sel == 16'(i + SCR_BASE))) begin
               sr_out = scratch_q[i];
            end
         end
      end
   end

   assign boot_mode      = boot_mode_q;
   assign sup_mode       = mode_q[0];
   assign instr_mem_over = mode_q[1];
   assign irq_en         = mode_q[2];

`ifdef SREGS_IRQ_EN
   assign irq_ack = irq_ack_q;
`else
   // Interrupt path compiled out: request is ignored
   logic unused_irq_req;
   assign unused_irq_req = irq_req;
   assign irq_ack        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sregs_ctl.md
# sregs_ctl

Parametrised special-register bank for the pcpu core. It holds the runtime mode (supervisor, instruction-memory override, interrupt enable), the boot/JTR mode with deferred commit on jump-class instructions, an interrupt save slot, and a configurable set of supervisor scratch registers. It sits beside the decoder: it is written by `srs`-type instructions, read back through `sr_out`, and drives mode control signals to fetch and the memory mux.

## Interface
- `DATA_W`, 16: SR data width; minimum 3.
- `NSCRATCH`, 4: number of scratch registers, SR4..SR(3+NSCRATCH); range 0..12.

Ports:
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sr_ie` in 1: SR write enable for this cycle.
- `sr_sel` in 16: binary SR index for both write and read.
- `sr_in` in DATA_W: write data.
- `instr_op` in 7: opcode of the instruction in execute.
- `irq_req` in 1: level interrupt request.
- `sr_out` out DATA_W: combinational readback of SR[`sr_sel`].
- `boot_mode` out 1: committed JTR mode.
- `instr_mem_over` out 1: SR1[1].
- `sup_mode` out 1: SR1[0].
- `irq_en` out 1: SR1[2].
- `irq_ack` out 1: one-cycle pulse when an interrupt is accepted.

## Operation
Register map, with unused bits reading 0:
- **SR1 MODE** [2:0] = {IE, INA, SUP}.
  - Writable only while SUP=1; the write is ignored while SUP=0.
  - The write takes effect at the next edge.
- **SR2 JTR**: bit0 writes `jtr_buf` unconditionally. Reads return {`jtr_buf`, `boot_mode`} in [1:0].
- **SR3 SAVE** [2:0]: holds SR1 captured at interrupt entry. Writable only while SUP=1.
- **SR4..SR(3+NSCRATCH) scratch**: full DATA_W.
  - Written only while SUP=1.
  - Read as 0 while SUP=0.
- **SR0 and out-of-range indices**: writes ignored, reads 0.

JTR commit:
- Occurs on any cycle where `instr_op` is 7'b0001110 or 7'b0001111, or `instr_op`=7'b0010001 with `sr_sel`=0. The last case is IRT.
- On commit, `boot_mode` <= `jtr_buf`.
- If an SR2 write happens in the same cycle as a commit, the commit uses the old `jtr_buf`. The new value is not forwarded.

Interrupt accept, when `irq_req` && IE && !IRT-this-cycle:
- SR3 <= SR1[2:0].
- SR1 <= 3'b001: SUP=1, INA=0, IE=0.
- `irq_ack` pulses.
- Because IE=0 after accept, a held `irq_req` is not re-accepted until software or IRT sets IE again.

IRT (`instr_op`=0010001, `sr_sel`=0): SR1 <= SR3[2:0] in addition to the JTR commit.

Priority in one cycle, highest first: IRT restore, then interrupt accept, then SR1 write. The losing SR1 update is dropped. An SR3 write that coincides with an accept is dropped; the accept's capture wins.

## Timing
- Reset values, applied asynchronously:
  - SR1 = 3'b001 (SUP=1, INA=0, IE=0).
  - `jtr_buf` = 1, `boot_mode` = 1.
  - SR3 = 0, scratch = 0.
  - `irq_ack` = 0.
  - Resulting outputs: `sup_mode`=1, `instr_mem_over`=0, `irq_en`=0.
- Write latency is 1 cycle: the value is visible on `sr_out` and the mode outputs after the edge.
- `sr_out` is combinational from `sr_sel` and current state, with no write-through.
- `irq_ack` is registered: high for exactly the cycle after the accepting edge. It is combinational-free from `irq_req`.
- Reset asserted mid-operation clears a pending `irq_ack` immediately. Any uncommitted `jtr_buf` value is lost, since `jtr_buf` returns to 1.

## Configuration
- `SREGS_IRQ_EN` defined: interrupt accept, SR3, IRT restore and `irq_ack` are compiled in as above.
- `SREGS_IRQ_EN` undefined:
  - `irq_ack` is tied to 0 and `irq_req` is ignored.
  - SR3 reads 0 and its writes are ignored.
  - IRT only performs the JTR commit.
  - SR1[2] (IE) remains a plain writable bit.

## Test plan
- **Reset:** pulse `rst_n`=0 mid-cycle → outputs immediately `sup_mode`=1, `instr_mem_over`=0, `boot_mode`=1, `irq_en`=0, `sr_out`(sel 1)=0x0001.
- **Privilege lock:**
  - Write SR1=0x0002 → next cycle `instr_mem_over`=1, `sup_mode`=0.
  - Then write SR1=0x0001 and SR4=0xBEEF → SR1 stays 0x0002 and SR4 reads 0.
- **JTR deferral:**
  - Write SR2=0 → `boot_mode` stays 1 across 3 idle cycles and `sr_out`(sel 2)=0b01.
  - Apply `instr_op`=0001110 → `boot_mode`=0 next cycle.
  - Repeat with 0010001 and `sr_sel`=5 → no commit.
- **Interrupt round trip (IRQ_EN):**
  - Set SR1=0x0007, then raise `irq_req` → next cycle SR1=0x0001, SR3=0x0007, and `irq_ack` is high for exactly one cycle.
  - Hold `irq_req` 5 cycles → no further ack.
  - IRT → SR1=0x0007.
- **Collisions:**
  - Same cycle: SR1 write 0x0003 with an accepted irq → SR1=0x0001.
  - Same cycle: IRT with `irq_req` and IE=1 → restore wins and no ack. The ack follows one cycle later if IE remains 1.
- **IRQ disabled build:** `SREGS_IRQ_EN` undefined, IE=1, `irq_req`=1 → `irq_ack` stays 0, SR3 reads 0, SR1 unchanged.
